// File: rtl/sha1_pkg.sv
// sha1_pkg: shared SHA-1 types, constants and round helpers
package sha1_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} sha1_state_t;
  localparam word_t H0_INIT [0:4] = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
  localparam word_t K_00_19 = 32'h5A827999;
  localparam word_t K_20_39 = 32'h6ED9EBA1;
  localparam word_t K_40_59 = 32'h8F1BBCDC;
  localparam word_t K_60_79 = 32'hCA62C1D6;
  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic word_t f_ch(input word_t b, input word_t c, input word_t d);
    return (b & c) | (~b & d);
  endfunction
  function automatic word_t f_par(input word_t b, input word_t c, input word_t d);
    return b ^ c ^ d;
  endfunction
  function automatic word_t f_maj(input word_t b, input word_t c, input word_t d);
    return (b & c) | (b & d) | (c & d);
  endfunction
  function automatic word_t sel_k(input logic [6:0] t);
    return t < 7'd20 ? K_00_19 : t < 7'd40 ? K_20_39 : t < 7'd60 ? K_40_59 : K_60_79;
  endfunction
  function automatic word_t sel_f(input logic [6:0] t, input word_t b, input word_t c, input word_t d);
    return t < 7'd20 ? f_ch(b, c, d) : (t < 7'd40 || t >= 7'd60) ? f_par(b, c, d) : f_maj(b, c, d);
  endfunction
  function automatic logic [159:0] sha1_round(input logic [6:0] t, input logic [159:0] s, input word_t w);
    word_t a, b, c, d, e, tmp;
    {a, b, c, d, e} = s;
    tmp = rotl(a, 5) + sel_f(t, b, c, d) + e + sel_k(t) + w;
    return {tmp, a, rotl(b, 30), c, d};
  endfunction
endpackage

// File: rtl/sha1_w_mem.sv
// sha1_w_mem: 16-word on-the-fly message schedule window (SHA1_CORE_UNROLL2_EN advances two words)
module sha1_w_mem import sha1_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  input  logic [511:0] block,
  output word_t        w0
`ifdef SHA1_CORE_UNROLL2_EN
  , output word_t      w1
`endif
);
  word_t w [0:15];
  // w[0] always holds W[t]; new words are appended at the tail as the head retires
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
    end else if (adv) begin
`ifdef SHA1_CORE_UNROLL2_EN
      for (int i = 0; i < 14; i++) w[i] <= w[i+2];
      w[14] <= rotl(w[13] ^ w[8] ^ w[2] ^ w[0], 1);
      w[15] <= rotl(w[14] ^ w[9] ^ w[3] ^ w[1], 1);
`else
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= rotl(w[13] ^ w[8] ^ w[2] ^ w[0], 1);
`endif
    end
  end
  assign w0 = w[0];
`ifdef SHA1_CORE_UNROLL2_EN
  assign w1 = w[1];
`endif
endmodule

// File: rtl/sha1_core.sv
// sha1_core: iterative SHA-1 block compression (SHA1_CORE_UNROLL2_EN: two rounds per clock)
module sha1_core import sha1_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         init_i,
  input  logic         next_i,
  input  logic [511:0] block_i,
  output logic         ready_o,
  output logic [159:0] digest_o,
  output logic         digest_valid_o
);
`ifdef SHA1_CORE_UNROLL2_EN
  localparam logic [6:0] T_STEP = 7'd2;
  localparam logic [6:0] T_LAST = 7'd78;
`else
  localparam logic [6:0] T_STEP = 7'd1;
  localparam logic [6:0] T_LAST = 7'd79;
`endif
  localparam logic [159:0] H0_VEC = {H0_INIT[0], H0_INIT[1], H0_INIT[2], H0_INIT[3], H0_INIT[4]};
  sha1_state_t state, state_n;
  logic [6:0] t;
  logic [159:0] v, hb, dig, sum, rnd;
  logic ready, dvalid, accept;
  word_t w0;
`ifdef SHA1_CORE_UNROLL2_EN
  word_t w1;
  sha1_w_mem u_w (.clk(clk), .rst(rst), .load(accept), .adv(state == ROUNDS), .block(block_i), .w0(w0), .w1(w1));
  assign rnd = sha1_round(t + 7'd1, sha1_round(t, v, w0), w1);
`else
  sha1_w_mem u_w (.clk(clk), .rst(rst), .load(accept), .adv(state == ROUNDS), .block(block_i), .w0(w0));
  assign rnd = sha1_round(t, v, w0);
`endif
  assign accept = ready & (init_i | next_i);
  for (genvar g = 0; g < 5; g++) begin : g_sum
    assign sum[32*g +: 32] = hb[32*g +: 32] + v[32*g +: 32];
  end
  // next-state: accept leaves IDLE, last round enters FINAL, FINAL returns to IDLE
  always_comb begin
    state_n = state == IDLE ? (accept ? ROUNDS : IDLE) : state == ROUNDS ? (t == T_LAST ? FINAL : ROUNDS) : IDLE;
  end
  // state register; ready mirrors the IDLE state one cycle ahead
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    ready <= rst | (state_n == IDLE);
  end
  // working registers, chaining base and digest update
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      hb <= '0;
      dig <= '0;
      t <= '0;
      dvalid <= 1'b0;
    end else if (accept) begin
      v <= init_i ? H0_VEC : dig;
      hb <= init_i ? H0_VEC : dig;
      t <= '0;
      dvalid <= 1'b0;
    end else if (state == ROUNDS) begin
      v <= rnd;
      t <= t + T_STEP;
    end else if (state == FINAL) begin
      dig <= sum;
      dvalid <= 1'b1;
    end
  end
  assign ready_o = ready;
  assign digest_o = dig;
  assign digest_valid_o = dvalid;
endmodule

// File: tb/tb_sha1_core.sv
// tb_sha1_core: directed SHA-1 vectors checked through a digest scoreboard
module tb_sha1_core;
`ifdef SHA1_CORE_UNROLL2_EN
  localparam int LAT = 41;
`else
  localparam int LAT = 81;
`endif
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2 = {480'h0, 32'h000001c0};
  localparam logic [159:0] D_ABC = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
  localparam logic [159:0] D_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
  localparam logic [159:0] D_TWO = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
  logic clk = 0, rst = 1, init_i = 0, next_i = 0;
  logic [511:0] block_i = '0;
  logic ready_o, digest_valid_o;
  logic [159:0] digest_o;
  int checks = 0, errors = 0;
  logic [160:0] exp_q [$];
  logic [160:0] e;
  logic prev_v = 0;
  logic busy_bad;
  sha1_core dut (.clk(clk), .rst(rst), .init_i(init_i), .next_i(next_i), .block_i(block_i),
                 .ready_o(ready_o), .digest_o(digest_o), .digest_valid_o(digest_valid_o));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // scoreboard monitor: each rising digest_valid_o consumes one expected entry
  always @(negedge clk) begin
    if (digest_valid_o && !prev_v && !rst) begin
      if (exp_q.size() == 0) chk("spurious_valid", {159'h0, digest_valid_o}, 160'h0);
      else begin
        e = exp_q.pop_front();
        if (e[160]) chk("digest", digest_o, e[159:0]);
      end
    end
    prev_v = digest_valid_o;
  end
  task automatic issue(input logic i, input logic n, input logic [511:0] blk, input logic push, input logic [159:0] d);
    init_i = i;
    next_i = n;
    block_i = blk;
    if (push) exp_q.push_back({1'b1, d});
    @(posedge clk);
    #1 init_i = 0;
    next_i = 0;
  endtask
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) chk("ready_timeout", {159'h0, ready_o}, 160'h1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", {159'h0, ready_o}, 160'h1);
    chk("rst_valid", {159'h0, digest_valid_o}, 160'h0);
    chk("rst_digest", digest_o, 160'h0);
    issue(1, 0, ABC, 1, D_ABC);
    block_i = EMPTY;
    busy_bad = 0;
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      busy_bad |= ready_o | digest_valid_o;
      if (k == 9 || k == 39) next_i = 1;
      if (k == 10 || k == 40) next_i = 0;
    end
    chk("busy_ready_low", {159'h0, busy_bad}, 160'h0);
    @(negedge clk);
    chk("done_ready", {159'h0, ready_o}, 160'h1);
    chk("done_valid", {159'h0, digest_valid_o}, 160'h1);
    exp_q.push_back({1'b0, 160'h0});
    issue(1, 0, B1, 0, '0);
    @(negedge clk);
    chk("valid_drop_init", {159'h0, digest_valid_o}, 160'h0);
    wait_ready();
    issue(0, 1, B2, 1, D_TWO);
    @(negedge clk);
    chk("valid_drop_next", {159'h0, digest_valid_o}, 160'h0);
    wait_ready();
    issue(1, 0, ABC, 1, D_ABC);
    wait_ready();
    issue(1, 1, EMPTY, 1, D_EMPTY);
    wait_ready();
    issue(1, 0, ABC, 0, '0);
    repeat (29) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_ready", {159'h0, ready_o}, 160'h1);
    chk("abort_valid", {159'h0, digest_valid_o}, 160'h0);
    chk("abort_digest", digest_o, 160'h0);
    issue(1, 0, ABC, 1, D_ABC);
    wait_ready();
    repeat (3) @(negedge clk);
    chk("queue_drained", 160'(exp_q.size()), 160'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha1_core.md
Name: sha1_core

Overview:
- Iterative SHA-1 compression engine (FIPS 180-4) that processes one 512-bit block at a time.
- Sits directly downstream of the HMAC control FSM.
  - It consumes that FSM's `init`/`next` strobes and block.
  - It returns the 160-bit chaining digest plus `ready` and `digest_valid`.
- Performs one round per clock, with the message schedule generated on the fly from a 16-word window.
- Padding is not handled here; the caller supplies pre-padded blocks.

Parameters:
- None. Fixed SHA-1 geometry. All constants live in the package.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `init_i` in 1: start a new hash; chaining state loaded from the standard H0..H4.
- `next_i` in 1: continue the hash; chaining state taken from the current digest registers.
- `block_i` in 512: message block, big-endian. W[0] = `block_i[511:480]`, W[15] = `block_i[31:0]`.
- `ready_o` out 1: core idle; `init_i`/`next_i` will be accepted.
- `digest_o` out 160: {H0,H1,H2,H3,H4}, with H0 in [159:128].
- `digest_valid_o` out 1: level; `digest_o` holds the result of the last accepted block.

Behaviour:
- Reset is synchronous and active-high. On `rst` at a clock edge:
  - State goes to IDLE.
  - `ready_o` = 1 and `digest_valid_o` = 0.
  - `digest_o` = 0, round counter = 0, and the working registers a..e are cleared.
  - Reset mid-operation aborts the block; no digest update occurs.
- The FSM has three states: IDLE, ROUNDS, FINAL. `ready_o` is a register, 1 only in IDLE.
- Accept:
  - Acceptance happens at an edge where `ready_o` = 1 and (`init_i` or `next_i`) = 1.
  - `block_i` is latched into the 16×32 W window.
  - a..e are loaded from the H0 constants (`init_i`) or from the digest registers (`next_i`). The H base registers are loaded with the same source.
  - `digest_valid_o` clears and `ready_o` clears. Counter t = 0, state moves to ROUNDS.
- Simultaneous `init_i` and `next_i`: `init_i` wins.
- Strobes while `ready_o` = 0 are ignored: no queuing and no error.
- `block_i` is sampled only at the accept edge.
- ROUNDS: one round per edge, using W[t]:
  - For t < 16, W[t] is the window head.
  - For t ≥ 16, W[t] = ROTL1(W[t-3]^W[t-8]^W[t-14]^W[t-16]). The window shifts by one word per round.
  - Round update: T = ROTL5(a)+f(t,b,c,d)+e+K(t)+W[t], all arithmetic mod 2^32. Then e←d, d←c, c←ROTL30(b), b←a, a←T.
  - f and K by round range:
    - t 0–19: Ch, K = 5A827999.
    - t 20–39: Parity, K = 6ED9EBA1.
    - t 40–59: Maj, K = 8F1BBCDC.
    - t 60–79: Parity, K = CA62C1D6.
  - At the edge with t = 79, go to FINAL.
- FINAL (one edge):
  - Hi ← Hbase_i + working register, mod 2^32 per word.
  - `digest_valid_o` ← 1, `ready_o` ← 1, state ← IDLE.
- Latency: accept at edge E0; rounds at E1..E80; FINAL at E81. `digest_valid_o` and `ready_o` are high in the cycle after E81.
  - Back-to-back: a new strobe may be accepted at E82, the first edge seen with `ready_o` = 1.
- `digest_o` is stable and `digest_valid_o` stays high until the next accept edge, at which `digest_valid_o` drops.
  - This ordering is mandatory so an upstream FSM waiting on `digest_valid_o` right after issuing `next` never sees a stale 1.
- `digest_o` is not cleared by accept; it changes only at FINAL.

Optional Feature:
- Macro `SHA1_CORE_UNROLL2_EN`.
- Defined:
  - Two rounds are performed per edge (t, t+1), and two schedule words are computed per edge.
  - The window shifts by two; t increments by 2.
  - The last ROUNDS edge is t = 78; FINAL is at E41, so the result is visible after E41.
  - Handshake and `digest_valid` semantics are unchanged.
- Undefined: one round per edge, 81-edge latency as above.
- The digest is bit-identical in both builds.

Decomposition:
- Package `sha1_pkg` holds:
  - `word_t` (logic [31:0]).
  - `H0_INIT[0:4]`, `K_00_19`, `K_20_39`, `K_40_59`, `K_60_79`.
  - State enum `sha1_state_t` {IDLE, ROUNDS, FINAL}.
  - Functions `rotl`, `f_ch`, `f_par`, `f_maj`, `sel_k(t)`, `sel_f(t,b,c,d)`.
- Sub-module `sha1_w_mem` holds the 16-word schedule window:
  - Load: block, on accept.
  - Shift: advance.
  - Outputs: W[t] (and W[t+1] under the macro).
- The round datapath and FSM stay in `sha1_core`.

Test Plan:
- "abc": `init` with block 61626380 00…00 00000018 → after E81, `digest_o` = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, `digest_valid_o` = 1.
- Empty message: `init` with block 80000000 0…0 → da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - `init` on block 1, then `next` on the padding block (length 0x1c0), issued at the first `ready` edge.
  - Expect 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - Check `digest_valid_o` = 0 in the cycle after the `next` accept.
- Strobes while busy:
  - Pulse `next_i` at E10 and E40 during "abc" → ignored; digest unchanged from the "abc" result.
  - `ready_o` low E1..E81.
- Simultaneous `init_i` and `next_i` while `digest_o` holds the "abc" result, block = empty-message block → da39a3ee… (`init` wins).
- Reset at E30 of a block → next cycle `ready_o` = 1, `digest_valid_o` = 0, `digest_o` = 0. A fresh "abc" `init` then yields the correct digest.
